// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls on data-cache misses, bubbles load-use hazards,
// squashes wrong-path work on EX redirects, and freezes the core on halt.
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        idex_memToReg,
    input  logic [4:0]  idex_dest,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ex_redirect,
    input  logic        halt_in,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        halt_out,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;

    logic memop;
    logic dstall;
    logic loaduse;
    logic halted;
    logic adv;

    assign memop   = mem_dREN | mem_dWEN;
    assign dstall  = memop & ~dhit;
    assign loaduse = idex_memToReg & (idex_dest != 5'd0)
                   & ((idex_dest == ifid_rs) | (idex_dest == ifid_rt));
    assign halted  = (state == HALT);

    // Any stage moves only when no data miss is pending and some memory completed.
    assign adv = ~halted & ~dstall & (ihit | dhit);

    assign idex_en    = adv;
    assign exmem_en   = adv;
    assign memwb_en   = adv;
    assign pc_en      = adv & ihit & (~loaduse | ex_redirect);
    assign ifid_en    = adv & ihit & ~loaduse & ~ex_redirect;
    assign ifid_flush = adv & (ex_redirect | ~ihit);
    assign idex_flush = adv & (ex_redirect | loaduse);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= RUN;
            halt_out <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_in) begin
                        state    <= HALT;
                        halt_out <= 1'b1;
                    end else if (dstall) begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (halt_in) begin
                        state    <= HALT;
                        halt_out <= 1'b1;
                    end else if (dhit) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    state    <= HALT;
                    halt_out <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    halt_out <= 1'b0;
                end
            endcase
        end
    end

    // A redirect held across a stall is counted only on the cycle it is accepted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (!halted) begin
            if (!pc_en && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (ex_redirect && adv && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    a_ifid_exclusive: assert property (@(posedge CLK) disable iff (!nRST)
        !(ifid_en && ifid_flush));
    a_halt_quiet: assert property (@(posedge CLK) disable iff (!nRST)
        halted |-> !(pc_en | ifid_en | ifid_flush | idex_en | idex_flush | exmem_en | memwb_en));
    a_flush_needs_adv: assert property (@(posedge CLK) disable iff (!nRST)
        (ifid_flush | idex_flush) |-> adv);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes expected responses
// computed by a behavioural model; a monitor pops and compares every cycle.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, idex_memToReg;
    logic [4:0]  idex_dest, ifid_rs, ifid_rt;
    logic        ex_redirect, halt_in;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic        halt_out;
    logic [15:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .idex_memToReg(idex_memToReg),
        .idex_dest(idex_dest), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ex_redirect(ex_redirect), .halt_in(halt_in),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .halt_out(halt_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rst_n;
        logic       ihit, dhit, dren, dwen, mtr;
        logic [4:0] dest, rs, rt;
        logic       redir, halt;
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctl;   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
        logic        halt_out;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   stim_done = 0;

    // Reference model: only "is the core halted" and the two counters are observable state.
    bit m_halted = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    function automatic logic [6:0] model_ctl(input stim_t s);
        logic stalled_on_miss, moving, hazard, fetch, squash;
        if (m_halted) return 7'b0;
        stalled_on_miss = (s.dren || s.dwen) && !s.dhit;
        moving = !stalled_on_miss && (s.ihit || s.dhit);
        hazard = s.mtr && s.dest != 0 && (s.dest == s.rs || s.dest == s.rt);
        if (!moving) return 7'b0;
        fetch  = s.ihit;
        squash = s.redir;
        return {fetch && (!hazard || squash),      // pc_en
                fetch && !hazard && !squash,       // ifid_en
                squash || !fetch,                  // ifid_flush
                1'b1,                              // idex_en
                squash || hazard,                  // idex_flush
                1'b1, 1'b1};                       // exmem_en, memwb_en
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        logic [6:0] c;
        @(posedge CLK);
        #1;
        nRST = s.rst_n; ihit = s.ihit; dhit = s.dhit; mem_dREN = s.dren; mem_dWEN = s.dwen;
        idex_memToReg = s.mtr; idex_dest = s.dest; ifid_rs = s.rs; ifid_rt = s.rt;
        ex_redirect = s.redir; halt_in = s.halt;
        if (!s.rst_n) begin
            m_halted = 0; m_stall = 0; m_flush = 0;
        end
        c = model_ctl(s);
        e.ctl = c; e.halt_out = m_halted; e.sc = 16'(m_stall); e.fc = 16'(m_flush);
        exp_q.push_back(e);
        // Advance the model to what the coming rising edge will commit.
        if (s.rst_n && !m_halted) begin
            if (!c[6] && m_stall < 65535) m_stall++;
            if (s.redir && c[3] && m_flush < 65535) m_flush++;
            if (s.halt) m_halted = 1;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.ihit  = 1'b1;
        s.rs    = 5'd1;
        s.rt    = 5'd2;
        return s;
    endfunction

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ctl", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}), 32'(e.ctl));
                check("halt_out", 32'(halt_out), 32'(e.halt_out));
                check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
                check("flush_cnt", 32'(flush_cnt), 32'(e.fc));
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        nRST = 1'b0;
        {ihit, dhit, mem_dREN, mem_dWEN, idex_memToReg, ex_redirect, halt_in} = '0;
        idex_dest = '0; ifid_rs = '0; ifid_rt = '0;

        s = idle(); s.rst_n = 1'b0;
        drive(s); drive(s);

        // Free run
        for (int i = 0; i < 10; i++) drive(idle());

        // Load-use on rt, then the same with r0 as destination
        s = idle(); s.mtr = 1; s.dest = 5'd5; s.rt = 5'd5;
        drive(s);
        s.dest = 5'd0; s.rs = 5'd0; s.rt = 5'd0;
        drive(s);

        // Data miss for three cycles, then dhit with no fetch
        s = idle(); s.ihit = 0; s.dren = 1;
        for (int i = 0; i < 3; i++) drive(s);
        s.dhit = 1;
        drive(s);
        drive(idle());

        // Simultaneous ihit/dhit with a store
        s = idle(); s.dhit = 1; s.dwen = 1;
        drive(s);

        // Redirect together with load-use; redirect held across a miss counts once
        s = idle(); s.redir = 1; s.mtr = 1; s.dest = 5'd7; s.rs = 5'd7;
        drive(s);
        s = idle(); s.redir = 1; s.dwen = 1;
        drive(s); drive(s);
        s.dhit = 1;
        drive(s);

        // Halt, frozen cycles, then reset pulse
        s = idle(); s.halt = 1;
        drive(s);
        s = idle(); s.redir = 1; s.ihit = 0;
        for (int i = 0; i < 4; i++) drive(s);
        s = idle(); s.rst_n = 0;
        drive(s);
        drive(idle());

        // Reset mid-DWAIT
        s = idle(); s.dren = 1; s.ihit = 0;
        drive(s); drive(s);
        s.rst_n = 0;
        drive(s);
        drive(idle());

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            s.rst_n = ($urandom_range(59) != 0);
            s.ihit  = $urandom_range(3) != 0;
            s.dhit  = $urandom_range(2) == 0;
            s.dren  = $urandom_range(3) == 0;
            s.dwen  = $urandom_range(5) == 0;
            s.mtr   = $urandom_range(1);
            s.dest  = 5'($urandom_range(3));
            s.rs    = 5'($urandom_range(3));
            s.rt    = 5'($urandom_range(3));
            s.redir = $urandom_range(4) == 0;
            s.halt  = $urandom_range(79) == 0;
            drive(s);
        end

        // Long forced stall with accepted redirects: both counters must saturate
        s = idle(); s.rst_n = 0;
        drive(s);
        s = idle(); s.ihit = 0; s.dhit = 1; s.redir = 1;
        for (int i = 0; i < 70000; i++) drive(s);
        s.halt = 1;
        drive(s);
        drive(idle());

        begin
            int budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                @(posedge CLK);
                budget--;
            end
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            end
        end
        stim_done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ihit  in  1  instruction fetch completed this cycle.
REQ-004 SHALL have port dhit  in  1  data access completed this cycle.
REQ-005 SHALL have port mem_dREN, mem_dWEN  in  1 each  load/store in MEM stage.
REQ-006 SHALL have port idex_memToReg  in  1  ID/EX holds a load.
REQ-007 SHALL have port idex_dest  in  5  ID/EX destination register.
REQ-008 SHALL have port ifid_rs, ifid_rt  in  5 each  IF/ID source registers.
REQ-009 SHALL have port ex_redirect  in  1  taken branch/jump/jr resolved in EX.
REQ-010 SHALL have port halt_in  in  1  halt instruction in MEM/WB.
REQ-011 SHALL have ports pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en  out  1 each  pipeline register controls.
REQ-012 SHALL have port halt_out  out  1  core halted (registered).
REQ-013 SHALL have ports stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-014 SHALL implement FSM states RUN, DWAIT, HALT (2-bit state register).
REQ-015 Derived: memop = mem_dREN|mem_dWEN; dstall = memop & ~dhit; loaduse = idex_memToReg & idex_dest!=0 & (idex_dest==ifid_rs | idex_dest==ifid_rt); adv = ~dstall & (ihit|dhit) in RUN/DWAIT, 0 in HALT.
REQ-016 Transitions: RUN->HALT on halt_in; RUN->DWAIT on dstall; DWAIT->RUN on dhit; DWAIT->HALT on halt_in; HALT sticky until nRST; halt_in has priority over dstall.
REQ-017 Outputs combinational from state and inputs (Mealy); halt_out registered = (state==HALT).
REQ-018 exmem_en = memwb_en = idex_en = adv.
REQ-019 pc_en = adv & ihit & (~loaduse | ex_redirect).
REQ-020 ifid_en = adv & ihit & ~loaduse & ~ex_redirect.
REQ-021 ifid_flush = adv & (ex_redirect | ~ihit); a dhit-only cycle inserts a bubble in IF/ID.
REQ-022 idex_flush = adv & (ex_redirect | loaduse); ex_redirect has priority over loaduse (load-use bubble discarded by redirect).
REQ-023 ifid_en and ifid_flush SHALL never both be 1; any flush output 1 implies its enable-or-advance condition held that cycle.
REQ-024 In HALT every enable and flush output SHALL be 0.
REQ-025 stall_cnt increments by 1 each cycle state!=HALT and pc_en=0; saturates at 16'hFFFF.
REQ-026 flush_cnt increments by 1 each cycle ex_redirect & adv; saturates at 16'hFFFF; held redirect across stall counts once (at acceptance).
REQ-027 Counters frozen in HALT; no wrap-around.
REQ-028 Simultaneous ihit & dhit with memop: dstall=0, full advance, ifid_en per REQ-020.

Reset
REQ-029 On nRST=0, asynchronously: state=RUN, halt_out=0, stall_cnt=0, flush_cnt=0.
REQ-030 Reset mid-DWAIT or mid-HALT SHALL return to RUN with no residual stall; outputs follow REQ-018..022 from the first cycle after release.

Verification
REQ-031 Free run: ihit=1, no hazards, 10 cycles -> all en=1, flushes=0, stall_cnt=0.
REQ-032 Load-use: idex_memToReg=1, idex_dest=5, ifid_rt=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, stall_cnt+1; idex_dest=0 same case -> no stall.
REQ-033 D-miss: mem_dREN=1, dhit=0 for 3 cycles then dhit=1, ihit=0 -> 3 cycles all en=0 state DWAIT, then exmem/memwb/idex_en=1, ifid_flush=1, state RUN, stall_cnt=4.
REQ-034 Redirect with load-use same cycle, ihit=1 -> pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=0, flush_cnt=1.
REQ-035 halt_in=1 -> next cycle halt_out=1, all outputs 0, counters frozen; nRST pulse -> halt_out=0, counters 0.
REQ-036 Force stall 70000 cycles -> stall_cnt holds 16'hFFFF.
